syscall_unit: RTL and testbench
===============================

# syscall_unit

Parametrised successor to the single-cycle CPU's syscall decoder. It sits beside the register file and takes `v0`/`a0` when the core executes `syscall`. It services print-int to the hex display, print-char into a buffered character stream with valid/ready handshake, and exit/exit2. Exits drain pending characters before asserting halt. It stalls the core whenever a request cannot complete in the current cycle.

## Interface
- `DATA_W`, 32: width of `a0`, `hex_out`, `ret_val`.
- `CODE_W`, 8: width of `v0`.
- `FIFO_DEPTH`, 8: character buffer entries; power of two, ≥2.

- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: syscall instruction in execute this cycle.
- `v0` in CODE_W: service code.
- `a0` in DATA_W: argument.
- `stall` out 1: combinational; core must hold the syscall (same `v0`/`a0`) while high.
- `halt` out 1: registered, sticky until reset.
- `exit_code` out 8: registered exit status.
- `hex_out` out DATA_W: registered display value.
- `ch_data` out 8: head of character FIFO.
- `ch_valid` out 1: FIFO non-empty.
- `ch_ready` in 1: consumer accepts head this cycle.
- `ret_val` out DATA_W: return value for `v0` writeback (only with macro).
- `ret_we` out 1: combinational writeback strobe.
- `err_bad_code` out 1: registered one-cycle pulse on unknown code.

## Operation
- States: RUN, DRAIN, HALTED. Reset → RUN.
- RUN, `enable`=1, service accepted when `stall`=0:
  - `v0`=1: `hex_out` ← `a0`.
  - `v0`=11: push `a0[7:0]`. If FIFO full, `stall`=1 and no push.
  - `v0`=10: `exit_code` ← 0, go to DRAIN.
  - `v0`=17: `exit_code` ← `a0[7:0]`, go to DRAIN.
  - Any other code: no state change. `err_bad_code`=1 next cycle. No stall.
- DRAIN: `stall`=1 always. Go to HALTED on the edge where the FIFO becomes empty, or immediately if it is already empty.
- HALTED: `halt`=1, `stall`=0, `enable` ignored (no pushes, no hex updates, no errors). Only reset leaves.
- FIFO:
  - Pop when `ch_valid`&`ch_ready`, in any state.
  - Full is taken from the registered count. When full, a push is refused even if a pop happens the same cycle.
  - Push and pop in the same cycle when not full: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits.
  - `ch_data` is undefined when `ch_valid`=0.
- Reset mid-operation: FIFO emptied, state RUN, buffered characters discarded.

## Timing
- Reset values:
  - `halt`=0, `exit_code`=0, `hex_out`=0, `err_bad_code`=0.
  - `ch_valid`=0, `ret_val`=0, `ret_we`=0.
  - FIFO count 0, cycle counter 0.
- `stall` = (RUN & `enable` & `v0`=11 & full) | DRAIN. Purely combinational.
- `hex_out` and pushed character are visible one edge after acceptance. A pushed character appears at `ch_valid` the cycle after the push.
- Exit with empty FIFO: accepted at edge N, DRAIN during cycle N→N+1, `halt`=1 from edge N+1.
- Exit with k characters queued and `ch_ready` held high: `halt`=1 one cycle after the last pop.

## Configuration
- `SYSCALL_CYCLE_COUNT_EN`:
  - Defined:
    - A DATA_W cycle counter increments every cycle except during reset, and wraps.
    - In RUN, `enable`&`v0`=30 drives `ret_val` = counter value and `ret_we`=1 combinationally, same cycle, with no stall.
  - Undefined:
    - No counter.
    - `ret_val`=0 and `ret_we`=0 constantly.
    - Code 30 is treated as unknown (`err_bad_code` pulse).

## Test plan
- Reset, then `enable`, `v0`=1, `a0`=0xDEADBEEF → `hex_out`=0xDEADBEEF after one edge. No stall, no error.
- `ch_ready`=0, push 8 chars 'A'..'H' → FIFO full. Push 'I' → `stall`=1 for every held cycle. Raise `ch_ready` for one cycle → 'A' popped, 'I' accepted the following cycle. Drain order is A..I.
- 3 chars queued, `ch_ready`=0, `v0`=17, `a0`=0x2A → `stall`=1, `halt`=0. Release `ch_ready` → `halt`=1 one cycle after the third pop, `exit_code`=0x2A.
- `v0`=10 with empty FIFO → `halt` at next edge, `exit_code`=0. Later syscalls (`v0`=1, 11) are ignored. Assert `reset` → `halt`=0, state RUN.
- `v0`=99 → `err_bad_code` pulses exactly one cycle. With `SYSCALL_CYCLE_COUNT_EN`, `v0`=30 at cycle 20 after reset → `ret_we`=1, `ret_val`=20. Without the macro, `v0`=30 → `err_bad_code` pulse.

Source files
------------

// File: rtl/syscall_unit_if.sv
// Core-side syscall request/writeback bus and the buffered character stream.
// The unit attaches through the slave modport; the core/consumer side uses master.
interface syscall_unit_if #(
    parameter int DATA_W = 32,
    parameter int CODE_W = 8
);
    logic              enable;
    logic [CODE_W-1:0] v0;
    logic [DATA_W-1:0] a0;
    logic              stall;
    logic [DATA_W-1:0] ret_val;
    logic              ret_we;
    logic [7:0]        ch_data;
    logic              ch_valid;
    logic              ch_ready;

    modport master (
        output enable, v0, a0, ch_ready,
        input  stall, ret_val, ret_we, ch_data, ch_valid
    );

    modport slave (
        input  enable, v0, a0, ch_ready,
        output stall, ret_val, ret_we, ch_data, ch_valid
    );
endinterface

// File: rtl/syscall_unit.sv
// Syscall service unit: hex display, buffered char output, exit with drain-before-halt.
// Optional feature macro: SYSCALL_CYCLE_COUNT_EN (cycle counter readable via code 30).
module syscall_unit #(
    parameter int DATA_W     = 32,
    parameter int CODE_W     = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    syscall_unit_if.slave       bus,
    output logic                halt,
    output logic [7:0]          exit_code,
    output logic [DATA_W-1:0]   hex_out,
    output logic                err_bad_code
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [CODE_W-1:0] CODE_HEX  = CODE_W'(32'd1);
    localparam logic [CODE_W-1:0] CODE_EXIT = CODE_W'(32'd10);
    localparam logic [CODE_W-1:0] CODE_PUT  = CODE_W'(32'd11);
    localparam logic [CODE_W-1:0] CODE_EX2  = CODE_W'(32'd17);
`ifdef SYSCALL_CYCLE_COUNT_EN
    localparam logic [CODE_W-1:0] CODE_CYC  = CODE_W'(32'd30);
`endif

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t            state_r, state_next_s;
    logic [7:0]        mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [PTR_W:0]    count_r, count_next_s;
    logic              halt_r, err_r;
    logic [7:0]        exit_code_r;
    logic [DATA_W-1:0] hex_r;

    logic run_req_s, full_s, push_s, pop_s, known_s, exit_s;
    logic is_hex_s, is_put_s, is_exit_s, is_ex2_s, is_cyc_s;

    // Request decode, FIFO handshake and the combinational stall.
    always_comb begin
        run_req_s = (state_r == RUN) && bus.enable;
        is_hex_s  = (bus.v0 == CODE_HEX);
        is_put_s  = (bus.v0 == CODE_PUT);
        is_exit_s = (bus.v0 == CODE_EXIT);
        is_ex2_s  = (bus.v0 == CODE_EX2);
`ifdef SYSCALL_CYCLE_COUNT_EN
        is_cyc_s  = (bus.v0 == CODE_CYC);
`else
        is_cyc_s  = 1'b0;
`endif
        known_s   = is_hex_s | is_put_s | is_exit_s | is_ex2_s | is_cyc_s;
        exit_s    = run_req_s && (is_exit_s || is_ex2_s);
        full_s    = (count_r == FULL_CNT);
        push_s    = run_req_s && is_put_s && !full_s;
        pop_s     = (count_r != '0) && bus.ch_ready;
        bus.stall = (run_req_s && is_put_s && full_s) || (state_r == DRAIN);
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + (PTR_W+1)'(1'b1);
            2'b01:   count_next_s = count_r - (PTR_W+1)'(1'b1);
            default: count_next_s = count_r;
        endcase
    end

    // Next-state logic; DRAIN leaves on the edge that empties the FIFO.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            RUN: begin
                if (exit_s) state_next_s = DRAIN;
                else        state_next_s = RUN;
            end
            DRAIN: begin
                if (count_next_s == '0) state_next_s = HALTED;
                else                    state_next_s = DRAIN;
            end
            HALTED:  state_next_s = HALTED;
            default: state_next_s = RUN;
        endcase
    end

    // State register and registered service outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= RUN;
            halt_r      <= 1'b0;
            err_r       <= 1'b0;
            exit_code_r <= 8'd0;
            hex_r       <= '0;
        end else begin
            state_r <= state_next_s;
            halt_r  <= (state_next_s == HALTED);
            err_r   <= run_req_s && !known_s;
            if (run_req_s && is_hex_s) hex_r <= bus.a0;
            if (run_req_s && is_exit_s)     exit_code_r <= 8'd0;
            else if (run_req_s && is_ex2_s) exit_code_r <= bus.a0[7:0];
        end
    end

    // FIFO pointers and occupancy; storage itself carries no reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            count_r <= count_next_s;
        end
    end

    // Character storage write port.
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wr_ptr_r] <= bus.a0[7:0];
    end

`ifdef SYSCALL_CYCLE_COUNT_EN
    logic [DATA_W-1:0] cyc_r;

    // Free-running wrap-around cycle counter.
    always_ff @(posedge clk) begin
        if (reset) cyc_r <= '0;
        else       cyc_r <= cyc_r + DATA_W'(1'b1);
    end

    assign bus.ret_we  = run_req_s && is_cyc_s;
    assign bus.ret_val = (run_req_s && is_cyc_s) ? cyc_r : '0;
`else
    assign bus.ret_we  = 1'b0;
    assign bus.ret_val = '0;
`endif

    assign bus.ch_valid = (count_r != '0);
    assign bus.ch_data  = mem_r[rd_ptr_r];
    assign halt         = halt_r;
    assign err_bad_code = err_r;
    assign exit_code    = exit_code_r;
    assign hex_out      = hex_r;
endmodule

// File: tb/tb_syscall_unit.sv
// Directed self-checking bench for syscall_unit: hex, char FIFO back-pressure,
// exit drain/halt, halted-state lockout, reset, bad code and the code-30 path.
module tb_syscall_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        halt;
    logic [7:0]  exit_code;
    logic [31:0] hex_out;
    logic        err_bad_code;
    logic [7:0]  exp_c;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    syscall_unit_if #(.DATA_W(32), .CODE_W(8)) bus ();

    syscall_unit #(.DATA_W(32), .CODE_W(8), .FIFO_DEPTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .halt         (halt),
        .exit_code    (exit_code),
        .hex_out      (hex_out),
        .err_bad_code (err_bad_code)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic en, input logic [7:0] code, input logic [31:0] arg);
        bus.enable = en;
        bus.v0     = code;
        bus.a0     = arg;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
    endtask

    initial begin
        req(1'b0, 8'd0, 32'd0);
        bus.ch_ready = 1'b0;
        do_reset;
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_exit", 32'(exit_code), 32'd0);
        chk("rst_hex", hex_out, 32'd0);
        chk("rst_err", 32'(err_bad_code), 32'd0);
        chk("rst_valid", 32'(bus.ch_valid), 32'd0);
        chk("rst_ret_we", 32'(bus.ret_we), 32'd0);
        chk("rst_ret_val", bus.ret_val, 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);

        // print-int
        req(1'b1, 8'd1, 32'hDEADBEEF);
        chk("hex_stall", 32'(bus.stall), 32'd0);
        tick;
        chk("hex_out", hex_out, 32'hDEADBEEF);
        chk("hex_err", 32'(err_bad_code), 32'd0);

        // fill FIFO with A..H, consumer stalled
        for (int i = 0; i < 8; i++) begin
            req(1'b1, 8'd11, 32'h41 + 32'(i));
            chk("push_stall", 32'(bus.stall), 32'd0);
            tick;
        end
        chk("full_valid", 32'(bus.ch_valid), 32'd1);
        chk("full_head", 32'(bus.ch_data), 32'h41);
        req(1'b1, 8'd11, 32'h49);
        chk("full_stall0", 32'(bus.stall), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("full_stall_hold", 32'(bus.stall), 32'd1);
            chk("full_head_hold", 32'(bus.ch_data), 32'h41);
        end
        bus.ch_ready = 1'b1;
        chk("full_pop_stall", 32'(bus.stall), 32'd1);
        tick;
        bus.ch_ready = 1'b0;
        chk("after_pop_stall", 32'(bus.stall), 32'd0);
        chk("after_pop_head", 32'(bus.ch_data), 32'h42);
        tick;
        req(1'b0, 8'd0, 32'd0);
        bus.ch_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_c = 8'h42 + 8'(i);
            chk("drain_valid", 32'(bus.ch_valid), 32'd1);
            chk("drain_data", 32'(bus.ch_data), 32'(exp_c));
            tick;
        end
        chk("drain_empty", 32'(bus.ch_valid), 32'd0);
        bus.ch_ready = 1'b0;

        // exit2 with three queued chars
        for (int i = 0; i < 3; i++) begin
            req(1'b1, 8'd11, 32'h78 + 32'(i));
            tick;
        end
        req(1'b1, 8'd17, 32'h2A);
        chk("ex2_accept_stall", 32'(bus.stall), 32'd0);
        tick;
        chk("drain_stall", 32'(bus.stall), 32'd1);
        chk("drain_halt", 32'(halt), 32'd0);
        tick;
        tick;
        chk("drain_stall_hold", 32'(bus.stall), 32'd1);
        chk("drain_halt_hold", 32'(halt), 32'd0);
        chk("drain_q_head", 32'(bus.ch_data), 32'h78);
        bus.ch_ready = 1'b1;
        tick;
        chk("pop1_halt", 32'(halt), 32'd0);
        tick;
        chk("pop2_halt", 32'(halt), 32'd0);
        tick;
        chk("ex2_halt", 32'(halt), 32'd1);
        chk("ex2_code", 32'(exit_code), 32'h2A);
        chk("halted_stall", 32'(bus.stall), 32'd0);
        chk("halted_empty", 32'(bus.ch_valid), 32'd0);
        bus.ch_ready = 1'b0;

        // halted: requests ignored
        req(1'b1, 8'd1, 32'h1234);
        tick;
        chk("halted_hex", hex_out, 32'hDEADBEEF);
        req(1'b1, 8'd11, 32'h55);
        tick;
        chk("halted_push", 32'(bus.ch_valid), 32'd0);
        req(1'b1, 8'd99, 32'd0);
        tick;
        chk("halted_err", 32'(err_bad_code), 32'd0);
        chk("halted_sticky", 32'(halt), 32'd1);
        req(1'b0, 8'd0, 32'd0);

        // reset leaves HALTED and discards buffered chars
        do_reset;
        chk("rst2_halt", 32'(halt), 32'd0);
        chk("rst2_exit", 32'(exit_code), 32'd0);
        chk("rst2_hex", hex_out, 32'd0);
        req(1'b1, 8'd11, 32'h33);
        tick;
        chk("run_again_push", 32'(bus.ch_valid), 32'd1);
        req(1'b0, 8'd0, 32'd0);
        do_reset;
        chk("rst_discard", 32'(bus.ch_valid), 32'd0);

        // exit with empty FIFO
        req(1'b1, 8'd10, 32'h77);
        chk("exit_accept_stall", 32'(bus.stall), 32'd0);
        tick;
        chk("exit_drain_stall", 32'(bus.stall), 32'd1);
        chk("exit_drain_halt", 32'(halt), 32'd0);
        tick;
        chk("exit_halt", 32'(halt), 32'd1);
        chk("exit_code0", 32'(exit_code), 32'd0);
        chk("exit_stall_off", 32'(bus.stall), 32'd0);
        req(1'b0, 8'd0, 32'd0);

        // unknown code
        do_reset;
        req(1'b1, 8'd99, 32'd0);
        chk("bad_stall", 32'(bus.stall), 32'd0);
        tick;
        chk("bad_err", 32'(err_bad_code), 32'd1);
        req(1'b0, 8'd0, 32'd0);
        tick;
        chk("bad_err_clear", 32'(err_bad_code), 32'd0);

        // code 30, twenty cycles after reset
        do_reset;
        repeat (20) tick;
        req(1'b1, 8'd30, 32'd0);
`ifdef SYSCALL_CYCLE_COUNT_EN
        chk("cyc_we", 32'(bus.ret_we), 32'd1);
        chk("cyc_val", bus.ret_val, 32'd20);
        chk("cyc_stall", 32'(bus.stall), 32'd0);
        tick;
        chk("cyc_err", 32'(err_bad_code), 32'd0);
`else
        chk("cyc_we_off", 32'(bus.ret_we), 32'd0);
        chk("cyc_val_off", bus.ret_val, 32'd0);
        tick;
        chk("cyc_err", 32'(err_bad_code), 32'd1);
`endif
        req(1'b0, 8'd0, 32'd0);
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
